unary_matmul: RTL and testbench



---
 rtl/unary_mm_pkg.sv | 19 +
 rtl/unary_matmul_if.sv | 22 ++
 rtl/unary_counter_bank.sv | 49 ++++
 rtl/unary_matmul.sv | 186 ++++++++++++++++++
 tb/tb_unary_matmul.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/unary_mm_pkg.sv
// Shared types and helpers for the unary (rate-coded) matrix multiplier.
package unary_mm_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

  localparam int MAG_MAX_W = 32;

  // Caller sign-extends into MAG_MAX_W and truncates the result back to WIDTH.
  // A negative full-scale value maps to 2^(WIDTH-1), which still fits WIDTH bits.
  function automatic logic [MAG_MAX_W-1:0] abs_mag(input logic [MAG_MAX_W-1:0] value,
                                                   input logic                 sign);
    return sign ? (~value + MAG_MAX_W'(1)) : value;
  endfunction

  function automatic int out_width(input int width, input int inner);
    return 2 * width + $clog2(inner + 1);
  endfunction

endpackage

// File: rtl/unary_matmul_if.sv
// Request/result bundle of the unary matrix multiplier.
interface unary_matmul_if
  import unary_mm_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int INNER = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 4,
  parameter int OUT_W = out_width(WIDTH, INNER)
) ();
  logic                        start;
  logic [ROWS*INNER*WIDTH-1:0] a_mat;
  logic [INNER*COLS*WIDTH-1:0] b_mat;
  logic                        ready;
  logic                        busy;
  logic                        done;
  logic [ROWS*COLS*OUT_W-1:0]  out;
  logic                        sat;

  modport master (output start, a_mat, b_mat, input ready, busy, done, out, sat);
  modport slave  (input start, a_mat, b_mat, output ready, busy, done, out, sat);
endinterface

// File: rtl/unary_counter_bank.sv
// Bank of N magnitude down-counters with shadow reload and a registered max magnitude.
module unary_counter_bank #(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      dec,
  input  logic                      reload,
  input  logic [N-1:0][WIDTH-1:0]   mag,
  output logic [N-1:0]              active,
  output logic [WIDTH-1:0]          max_mag,
  output logic                      none
);
  logic [N-1:0][WIDTH-1:0] cnt, init;
  logic [WIDTH-1:0]        max_c;

  always_comb begin
    max_c = '0;
    for (int i = 0; i < N; i++)
      if (mag[i] > max_c) max_c = mag[i];
  end

  // max_mag never drops below 1 so the sweep length stays non-zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      init    <= '0;
      max_mag <= '0;
      none    <= 1'b1;
    end else if (load) begin
      cnt     <= mag;
      init    <= mag;
      max_mag <= (max_c == '0) ? WIDTH'(1) : max_c;
      none    <= (max_c == '0);
    end else if (reload) begin
      cnt <= init;
    end else if (dec) begin
      for (int i = 0; i < N; i++)
        if (cnt[i] != '0) cnt[i] <= cnt[i] - WIDTH'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign active[i] = |cnt[i];
  end

endmodule

// File: rtl/unary_matmul.sv
// Signed ROWS x INNER by INNER x COLS unary matrix multiplier, one k slice per LOAD/SWEEP.
// Build option: UNARY_MATMUL_SAT_EN adds per-step saturation and a sticky sat flag.
module unary_matmul
  import unary_mm_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int INNER = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 4,
  parameter int OUT_W = out_width(WIDTH, INNER)
) (
  input  logic           clk,
  input  logic           reset,
  unary_matmul_if.slave  bus
);
  localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;

  state_t state, state_nx;

  logic [ROWS-1:0][INNER-1:0][WIDTH-1:0] a_q;
  logic [INNER-1:0][COLS-1:0][WIDTH-1:0] b_q;
  logic [KW-1:0]                         k;
  logic [WIDTH-1:0]                      sc, rc;

  logic [ROWS-1:0][WIDTH-1:0] a_sel, a_mag;
  logic [COLS-1:0][WIDTH-1:0] b_sel, b_mag;
  logic [ROWS-1:0]            a_neg_now, a_neg, row_act;
  logic [COLS-1:0]            b_neg_now, b_neg, col_act;
  logic [ROWS-1:0][COLS-1:0]  neg;

  logic [WIDTH-1:0] s_max, t_max, s_eff, t_eff;
  logic             row_none, col_none;
  logic             accept, wrap, last, last_k;

  logic [ROWS-1:0][COLS-1:0][OUT_W-1:0] acc;

  // Column k of A and row k of B, reduced to magnitude + sign
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int kk = 0; kk < INNER; kk++) begin
      if (k == KW'(kk)) begin
        for (int i = 0; i < ROWS; i++) a_sel[i] = a_q[i][kk];
        for (int j = 0; j < COLS; j++) b_sel[j] = b_q[kk][j];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      a_neg_now[i] = a_sel[i][WIDTH-1];
      a_mag[i]     = WIDTH'(abs_mag(MAG_MAX_W'($signed(a_sel[i])), a_sel[i][WIDTH-1]));
    end
    for (int j = 0; j < COLS; j++) begin
      b_neg_now[j] = b_sel[j][WIDTH-1];
      b_mag[j]     = WIDTH'(abs_mag(MAG_MAX_W'($signed(b_sel[j])), b_sel[j][WIDTH-1]));
    end
  end

  unary_counter_bank #(.N(ROWS), .WIDTH(WIDTH)) u_rows (
    .clk     (clk),
    .reset   (reset),
    .load    (state == LOAD),
    .dec     (wrap),
    .reload  (1'b0),
    .mag     (a_mag),
    .active  (row_act),
    .max_mag (s_max),
    .none    (row_none)
  );

  unary_counter_bank #(.N(COLS), .WIDTH(WIDTH)) u_cols (
    .clk     (clk),
    .reset   (reset),
    .load    (state == LOAD),
    .dec     (state == SWEEP),
    .reload  (wrap),
    .mag     (b_mag),
    .active  (col_act),
    .max_mag (t_max),
    .none    (col_none)
  );

  // A zero operand on either side makes the whole slice a single idle sweep cycle
  assign s_eff  = (row_none || col_none) ? WIDTH'(1) : s_max;
  assign t_eff  = (row_none || col_none) ? WIDTH'(1) : t_max;
  assign accept = (state == IDLE) && bus.start;
  assign wrap   = (state == SWEEP) && (sc == t_eff - WIDTH'(1));
  assign last   = wrap && (rc == s_eff - WIDTH'(1));
  assign last_k = (k == KW'(INNER - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = LOAD;
      LOAD:    state_nx = SWEEP;
      SWEEP:   if (last) state_nx = last_k ? DONE : LOAD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      k     <= '0;
      sc    <= '0;
      rc    <= '0;
      a_neg <= '0;
      b_neg <= '0;
    end else begin
      if (accept) begin
        a_q <= bus.a_mat;
        b_q <= bus.b_mat;
        k   <= '0;
      end
      if (state == LOAD) begin
        a_neg <= a_neg_now;
        b_neg <= b_neg_now;
        sc    <= '0;
        rc    <= '0;
      end
      if (state == SWEEP) begin
        if (wrap) begin
          sc <= '0;
          rc <= rc + WIDTH'(1);
        end else begin
          sc <= sc + WIDTH'(1);
        end
        if (last && !last_k) k <= k + KW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        neg[i][j] = a_neg[i] ^ b_neg[j];
  end

`ifdef UNARY_MATMUL_SAT_EN
  localparam logic [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  logic sat_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (state == SWEEP) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          if (row_act[i] && col_act[j]) begin
            if (neg[i][j] ? (acc[i][j] == ACC_MIN) : (acc[i][j] == ACC_MAX))
              sat_q <= 1'b1;
            else
              acc[i][j] <= neg[i][j] ? acc[i][j] - OUT_W'(1) : acc[i][j] + OUT_W'(1);
          end
    end
  end

  assign bus.sat = sat_q;
`else
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      acc <= '0;
    end else if (state == SWEEP) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          if (row_act[i] && col_act[j])
            acc[i][j] <= neg[i][j] ? acc[i][j] - OUT_W'(1) : acc[i][j] + OUT_W'(1);
    end
  end

  assign bus.sat = 1'b0;
`endif

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == LOAD) || (state == SWEEP);
  assign bus.done  = (state == DONE);
  assign bus.out   = acc;

endmodule

// File: tb/tb_unary_matmul.sv
// Scoreboard bench for unary_matmul: default 4x4x4, a 1x1x1 instance and a narrow-output instance.
module tb_unary_matmul;
  import unary_mm_pkg::*;

  localparam int R   = 4;
  localparam int K   = 4;
  localparam int C   = 4;
  localparam int W   = 4;
  localparam int OW  = out_width(W, K);
  localparam int OW1 = out_width(W, 1);
  localparam int SOW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unary_matmul_if #(.ROWS(R), .INNER(K), .COLS(C), .WIDTH(W), .OUT_W(OW))  bus ();
  unary_matmul_if #(.ROWS(1), .INNER(1), .COLS(1), .WIDTH(W), .OUT_W(OW1)) bus1 ();
  unary_matmul_if #(.ROWS(R), .INNER(K), .COLS(C), .WIDTH(W), .OUT_W(SOW)) bus_s ();

  unary_matmul #(.ROWS(R), .INNER(K), .COLS(C), .WIDTH(W), .OUT_W(OW))  dut   (.clk(clk), .reset(reset), .bus(bus));
  unary_matmul #(.ROWS(1), .INNER(1), .COLS(1), .WIDTH(W), .OUT_W(OW1)) dut1  (.clk(clk), .reset(reset), .bus(bus1));
  unary_matmul #(.ROWS(R), .INNER(K), .COLS(C), .WIDTH(W), .OUT_W(SOW)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  typedef struct {
    logic [R*C*OW-1:0] out;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   am[R][K];
  int   bm[K][C];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference matmul plus the expected sweep cost of every k slice
  function automatic exp_t model();
    exp_t e;
    int   s, ma, mb, v;
    e.out = '0;
    e.lat = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) s += am[i][k] * bm[k][j];
        e.out[(i*C+j)*OW +: OW] = OW'(s);
      end
    for (int k = 0; k < K; k++) begin
      ma = 0;
      mb = 0;
      for (int i = 0; i < R; i++) begin v = (am[i][k] < 0) ? -am[i][k] : am[i][k]; if (v > ma) ma = v; end
      for (int j = 0; j < C; j++) begin v = (bm[k][j] < 0) ? -bm[k][j] : bm[k][j]; if (v > mb) mb = v; end
      e.lat += (ma == 0 || mb == 0) ? 2 : 1 + ma * mb;
    end
    return e;
  endfunction

  task automatic set_ops();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K; k++) bus.a_mat[(i*K+k)*W +: W] = W'(am[i][k]);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < C; j++) bus.b_mat[(k*C+j)*W +: W] = W'(bm[k][j]);
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) am[i][k] = av;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) bm[k][j] = bv;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) am[i][k] = int'($urandom_range(15)) - 8;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) bm[k][j] = int'($urandom_range(15)) - 8;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 3000) begin @(posedge clk); #1; n++; end
  endtask

  // Counts edges after the accept edge until done is seen
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 3000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic check_head(input string tag, input int n);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " lat"}, n, e.lat);
    chk({tag, " out"}, bus.out, e.out);
  endtask

  task automatic run_op(input string tag);
    int n;
    wait_ready();
    set_ops();
    bus.start = 1'b1;
    @(posedge clk);
    sb.push_back(model());
    #1 bus.start = 1'b0;
    wait_done(n);
    check_head(tag, n);
  endtask

  initial begin
    int n;
    logic [OW1-1:0]     o1;
    logic [R*C*SOW-1:0] so;

    reset = 1'b1;
    bus.start = 1'b0;   bus.a_mat = '0;   bus.b_mat = '0;
    bus1.start = 1'b0;  bus1.a_mat = '0;  bus1.b_mat = '0;
    bus_s.start = 1'b0; bus_s.a_mat = '0; bus_s.b_mat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", bus.ready, 1);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst out", bus.out, 0);
    chk("rst sat", bus_s.sat, 0);
    reset = 1'b0;

    // 1x1x1: 3 * -2
    bus1.a_mat = 4'd3;
    bus1.b_mat = 4'hE;
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    chk("u1 ready_low", bus1.ready, 0);
    chk("u1 busy", bus1.busy, 1);
    n = 0;
    while (!bus1.done && n < 200) begin @(posedge clk); #1; n++; end
    o1 = OW1'(-6);
    chk("u1 lat", n, 7);
    chk("u1 out", bus1.out, o1);

    // directed extremes and zero operands
    fill(-8, -8); run_op("neg_neg");
    fill(7, -8);  run_op("pos_neg");
    fill(0, 7);   run_op("zero_a");
    chk("zero_a out_zero", bus.out, 0);
    fill(-8, 0);  run_op("zero_b");
    for (int i = 0; i < R; i++) for (int k = 0; k < K; k++) am[i][k] = (i == k) ? -1 : 0;
    for (int k = 0; k < K; k++) for (int j = 0; j < C; j++) bm[k][j] = int'($urandom_range(15)) - 8;
    run_op("neg_ident");

    for (int t = 0; t < 100; t++) begin
      rand_ops();
      run_op("rand");
    end

    // reset in the middle of a sweep
    fill(7, 7);
    wait_ready();
    set_ops();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst ready", bus.ready, 1);
    chk("mid_rst busy", bus.busy, 0);
    chk("mid_rst out", bus.out, 0);
    reset = 1'b0;
    rand_ops();
    run_op("after_rst");

    // start held high, operands changed after accept
    rand_ops();
    wait_ready();
    set_ops();
    bus.start = 1'b1;
    @(posedge clk);
    sb.push_back(model());
    #1;
    rand_ops();
    set_ops();
    sb.push_back(model());
    wait_done(n);
    check_head("hold1", n);
    @(posedge clk);
    #1;
    chk("hold idle_ready", bus.ready, 1);
    @(posedge clk);
    #1;
    chk("hold reaccept", bus.busy, 1);
    bus.start = 1'b0;
    wait_done(n);
    check_head("hold2", n);

    // narrow output: every cell reaches +256
    bus_s.a_mat = {(R*K){4'h8}};
    bus_s.b_mat = {(K*C){4'h8}};
    bus_s.start = 1'b1;
    @(posedge clk);
    #1 bus_s.start = 1'b0;
    n = 0;
    while (!bus_s.done && n < 3000) begin @(posedge clk); #1; n++; end
    chk("sat lat", n, 4 * 65);
    for (int c = 0; c < R * C; c++) begin
`ifdef UNARY_MATMUL_SAT_EN
      so[c*SOW +: SOW] = SOW'((1 << (SOW - 1)) - 1);
`else
      so[c*SOW +: SOW] = SOW'(256);
`endif
    end
    chk("sat out", bus_s.out, so);
`ifdef UNARY_MATMUL_SAT_EN
    chk("sat flag", bus_s.sat, 1);
`else
    chk("sat flag", bus_s.sat, 0);
`endif
    chk("sat main_flag", bus.sat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
